instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk input 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst input 1: reset, synchronous, active-high.
REQ-005 SHALL have port PCSrc_i input 1: redirect request from the control unit; sampled every cycle.
REQ-006 SHALL have port PCTarget_i input 32: redirect address; valid when PCSrc_i=1.
REQ-007 SHALL have port imem_req_o output 1: instruction memory request.
REQ-008 SHALL have port imem_addr_o output 32: request address; always word-aligned.
REQ-009 SHALL have port imem_ack_i input 1: memory response valid; imem_rdata_i is captured in this cycle.
REQ-010 SHALL have port imem_rdata_i input INSTR_WIDTH: fetched instruction word.
REQ-011 SHALL have port instr_o output INSTR_WIDTH: instruction presented to the decoder.
REQ-012 SHALL have port pc_o output 32: address of instr_o.
REQ-013 SHALL have port instr_valid_o output 1: instr_o/pc_o are valid.
REQ-014 SHALL have port instr_ready_i input 1: the decoder accepts the instruction; transfer occurs when instr_valid_o & instr_ready_i.

Function
REQ-015 SHALL hold a 2-entry FIFO of {pc, instr}; instr_o/pc_o/instr_valid_o come from the head entry and are registered.
REQ-016 SHALL implement FSM states IDLE, REQ and DROP.
REQ-017 IDLE: imem_req_o=0; go to REQ when FIFO occupancy minus pops this cycle < 2.
REQ-018 REQ: imem_req_o=1 and imem_addr_o held stable until imem_ack_i=1 (no cancellation).
REQ-019 On ack in REQ: push {imem_addr_o, imem_rdata_i}; fetch PC += 4. Stay in REQ (new address next cycle) if space remains after the push; otherwise go to IDLE.
REQ-020 imem_ack_i SHALL be legal in the first cycle of imem_req_o, giving zero wait state and one instruction per cycle sustained when instr_ready_i=1.
REQ-021 Fetch PC increment SHALL wrap modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-022 On PCSrc_i=1: flush the FIFO, so instr_valid_o=0 next cycle; fetch PC becomes {PCTarget_i[31:2], 2'b00}.
REQ-023 A transfer at the head in the same cycle as PCSrc_i=1 SHALL count as completed.
REQ-024 PCSrc_i=1 in IDLE: go to REQ at the target next cycle.
REQ-025 PCSrc_i=1 in REQ without ack: go to DROP; the in-flight request stays asserted.
REQ-026 PCSrc_i=1 in REQ with ack in the same cycle: discard the ack data; go to REQ at the target.
REQ-027 DROP: imem_req_o=1 with the old address until ack; discard the response; then go to REQ at the latest target.
REQ-028 A further PCSrc_i in DROP SHALL overwrite the stored target.
REQ-029 A push and a pop in the same cycle SHALL keep occupancy unchanged.
REQ-030 The FIFO SHALL never be pushed when full; this is guaranteed by the REQ-017 space check.
REQ-031 instr_o/pc_o SHALL hold their values while instr_valid_o=1 and instr_ready_i=0.

Reset
REQ-032 While rst=1: state IDLE, FIFO empty, fetch PC=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=0.
REQ-033 rst SHALL override PCSrc_i and imem_ack_i in the same cycle.
REQ-034 The first imem_req_o SHALL assert in the first cycle after rst deasserts.
REQ-035 Reset mid-request SHALL abandon the request; the bench SHALL not deliver a stale ack after reset.

Verification
REQ-036 Zero-wait stream, ready=1, RESET_PC=0: pc_o sequence 0,4,8,C, one per cycle after a 2-cycle startup.
REQ-037 Stall: ready=0 for 5 cycles: at most 2 entries buffered, imem_req_o drops, head pc_o is stable; on ready=1, pc_o resumes in order with no gaps or duplicates.
REQ-038 Redirect with PCSrc_i=1, PCTarget_i=32'h100 while a 3-wait request to 32'h8 is pending: the 32'h8 data is never presented; the next instr_valid_o shows pc_o=32'h100.
REQ-039 PCSrc_i on the ack cycle and PCTarget_i=32'h203: the ack data is dropped; imem_addr_o=32'h200 next cycle.
REQ-040 Wrap: RESET_PC=32'hFFFF_FFF8 gives pc_o sequence FFFFFFF8, FFFFFFFC, 00000000.
REQ-041 rst asserted mid-stream: next cycle instr_valid_o=0, imem_req_o=0; after release, the first imem_addr_o=RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch -- instruction fetch unit with a 2-entry {pc, instr} buffer.
//
// The unit issues word-aligned requests to instruction memory and buffers up to
// two returned words. The decoder sees the head entry directly from flops.
// A redirect (PCSrc_i) flushes the buffer and restarts fetching at the target.
// A request already issued to memory is never cancelled. If the redirect
// arrives while a request is still waiting, the unit enters DROP. In DROP it
// keeps the old request up until the ack arrives, then discards the returned
// data.
//
// Handshakes:
//   imem: imem_req_o/imem_addr_o stay asserted and stable until imem_ack_i=1.
//         imem_rdata_i is captured in the ack cycle. An ack may arrive in the
//         first cycle of a request.
//   decoder: an entry transfers on a rising edge where
//         instr_valid_o & instr_ready_i. While instr_valid_o=1 and
//         instr_ready_i=0, instr_o/pc_o hold their values.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   PCSrc_i           redirect request (sampled every cycle)
//   PCTarget_i        redirect address; bits [1:0] are ignored
//   imem_req_o        memory request
//   imem_addr_o       memory request address
//   imem_ack_i        memory response valid
//   imem_rdata_i      memory response data
//   instr_o           instruction at the buffer head
//   pc_o              address of instr_o
//   instr_valid_o     the head entry is valid
//   instr_ready_i     the decoder accepts the head entry
//   state_dbg_o       current FSM state (0=IDLE, 1=REQ, 2=DROP)
module instr_fetch #(
  parameter int          INSTR_WIDTH = 32,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   PCSrc_i,
  input  logic [31:0]            PCTarget_i,
  output logic                   imem_req_o,
  output logic [31:0]            imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [31:0]            pc_o,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [1:0]             state_dbg_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  // fetch_pc_q is the address being requested. In DROP it still holds the
  // stale address while target_q holds the latest redirect target.
  logic [31:0]            fetch_pc_q, fetch_pc_d;
  logic [31:0]            target_q, target_d;
  // Shift-style buffer: entry 0 is always the head.
  logic [31:0]            e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
  logic [INSTR_WIDTH-1:0] e0_instr_q, e0_instr_d, e1_instr_q, e1_instr_d;
  logic                   e0_vld_q, e0_vld_d, e1_vld_q, e1_vld_d;

  logic        pop;
  logic        push;
  logic        req;
  logic [1:0]  occ_after_pop;
  logic [31:0] tgt_aligned;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    e0_pc_d    = e0_pc_q;
    e0_instr_d = e0_instr_q;
    e0_vld_d   = e0_vld_q;
    e1_pc_d    = e1_pc_q;
    e1_instr_d = e1_instr_q;
    e1_vld_d   = e1_vld_q;
    push       = 1'b0;
    req        = 1'b0;

    tgt_aligned   = {PCTarget_i[31:2], 2'b00};
    pop           = e0_vld_q & instr_ready_i;
    occ_after_pop = {1'b0, e0_vld_q} + {1'b0, e1_vld_q} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (PCSrc_i) begin
          fetch_pc_d = tgt_aligned;
          state_d    = S_REQ;
        end else if (occ_after_pop < 2'd2) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        req = 1'b1;
        if (PCSrc_i) begin
          if (imem_ack_i) begin
            fetch_pc_d = tgt_aligned;
          end else begin
            target_d = tgt_aligned;
            state_d  = S_DROP;
          end
        end else if (imem_ack_i) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          // Keep requesting only if a slot is still free after this push.
          if (occ_after_pop != 2'd0) state_d = S_IDLE;
        end
      end
      S_DROP: begin
        req = 1'b1;
        if (PCSrc_i) target_d = tgt_aligned;
        if (imem_ack_i) begin
          fetch_pc_d = PCSrc_i ? tgt_aligned : target_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (PCSrc_i) begin
      // Flush. A pop in this same cycle has already been completed.
      e0_vld_d = 1'b0;
      e1_vld_d = 1'b0;
    end else begin
      if (pop) begin
        e0_pc_d    = e1_pc_q;
        e0_instr_d = e1_instr_q;
        e0_vld_d   = e1_vld_q;
        e1_vld_d   = 1'b0;
      end
      if (push) begin
        if (!e0_vld_d) begin
          e0_pc_d    = fetch_pc_q;
          e0_instr_d = imem_rdata_i;
          e0_vld_d   = 1'b1;
        end else begin
          e1_pc_d    = fetch_pc_q;
          e1_instr_d = imem_rdata_i;
          e1_vld_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      target_q   <= RESET_PC;
      e0_pc_q    <= '0;
      e0_instr_q <= '0;
      e0_vld_q   <= 1'b0;
      e1_pc_q    <= '0;
      e1_instr_q <= '0;
      e1_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      target_q   <= target_d;
      e0_pc_q    <= e0_pc_d;
      e0_instr_q <= e0_instr_d;
      e0_vld_q   <= e0_vld_d;
      e1_pc_q    <= e1_pc_d;
      e1_instr_q <= e1_instr_d;
      e1_vld_q   <= e1_vld_d;
    end
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_o       = e0_instr_q;
  assign pc_o          = e0_pc_q;
  assign instr_valid_o = e0_vld_q;
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch. The main instance uses RESET_PC=0 and a
// memory model with a programmable wait count. The second instance uses
// RESET_PC=FFFFFFF8 and a zero-wait memory to exercise address wrap.
// Memory data is addr ^ 32'hDEADBEEF.
module tb_instr_fetch;

  localparam logic [31:0] K       = 32'hDEAD_BEEF;
  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_REQ  = 2'd1;
  localparam logic [1:0]  ST_DROP = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        pcsrc = 1'b0;
  logic [31:0] pctarget = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;
  logic        ready = 1'b1;
  logic [1:0]  state;

  logic        w_rst = 1'b1;
  logic        w_pcsrc = 1'b0;
  logic [31:0] w_target = 32'h0;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_valid;
  logic        w_ready = 1'b1;
  logic [1:0]  w_state;

  int n_checks = 0;
  int n_fail   = 0;
  int wait_cycles = 0;
  int wait_cnt    = 0;

  instr_fetch #(.INSTR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .PCSrc_i(pcsrc), .PCTarget_i(pctarget),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack),
    .imem_rdata_i(imem_rdata), .instr_o(instr), .pc_o(pc),
    .instr_valid_o(valid), .instr_ready_i(ready), .state_dbg_o(state)
  );

  instr_fetch #(.INSTR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(w_rst), .PCSrc_i(w_pcsrc), .PCTarget_i(w_target),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_ack_i(w_ack),
    .imem_rdata_i(w_rdata), .instr_o(w_instr), .pc_o(w_pc),
    .instr_valid_o(w_valid), .instr_ready_i(w_ready), .state_dbg_o(w_state)
  );

  // Zero-wait memory for the wrap instance.
  assign w_ack   = w_req;
  assign w_rdata = w_addr ^ K;

  // Main memory model. It acks after wait_cycles cycles of request and
  // drives the response on the falling edge.
  always @(negedge clk) begin
    if (imem_req === 1'b1) begin
      if (wait_cnt >= wait_cycles) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr ^ K;
        wait_cnt   = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 00000000", pc); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 00000000", instr); end
    n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, ST_IDLE); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    wait_cycles = 0;
    ready = 1'b1;
    rst = 1'b0;
    step();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h want 00000000", imem_addr); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (valid !== 1'b1 || pc !== exp_pc[i]) begin n_fail++; $display("FAIL stream_pc[%0d]: got valid=%b pc=%h want valid=1 pc=%h", i, valid, pc, exp_pc[i]); end
      n_checks++; if (instr !== (exp_pc[i] ^ K)) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", i, instr, exp_pc[i] ^ K); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h10, 32'h14, 32'h18};
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (valid !== 1'b1 || pc !== 32'hC || instr !== (32'hC ^ K)) begin n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b pc=%h instr=%h want valid=1 pc=0000000c instr=%h", i, valid, pc, instr, 32'hC ^ K); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req); end
    end
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (valid !== 1'b1 || pc !== exp_pc[i]) begin n_fail++; $display("FAIL stall_resume[%0d]: got valid=%b pc=%h want valid=1 pc=%h", i, valid, pc, exp_pc[i]); end
    end
  endtask

  task automatic test_redirect_wait();
    bit found;
    rst = 1'b1; ready = 1'b0; wait_cycles = 0;
    step();
    rst = 1'b0;
    step();              // IDLE -> REQ 0
    step();              // push 0
    step();              // push 4, buffer full
    n_checks++; if (imem_req !== 1'b0 || pc !== 32'h0) begin n_fail++; $display("FAIL rw_full: got req=%b pc=%h want req=0 pc=00000000", imem_req, pc); end
    wait_cycles = 3;
    ready = 1'b1;
    step();              // request to 8 starts, 3 waits
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL rw_pending: got req=%b addr=%h want req=1 addr=00000008", imem_req, imem_addr); end
    pcsrc = 1'b1; pctarget = 32'h100;
    step();
    pcsrc = 1'b0;
    n_checks++; if (state !== ST_DROP || imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL rw_drop: got state=%0d req=%b addr=%h want state=2 req=1 addr=00000008", state, imem_req, imem_addr); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rw_flush: got valid=%b want 0", valid); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (valid === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found || pc !== 32'h100 || instr !== (32'h100 ^ K)) begin n_fail++; $display("FAIL rw_target: got found=%b pc=%h instr=%h want pc=00000100 instr=%h", found, pc, instr, 32'h100 ^ K); end
  endtask

  task automatic test_redirect_ack();
    wait_cycles = 0;
    pcsrc = 1'b1; pctarget = 32'h203;
    step();
    pcsrc = 1'b0;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ra_flush: got valid=%b want 0", valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || state !== ST_REQ) begin n_fail++; $display("FAIL ra_addr: got req=%b addr=%h state=%0d want req=1 addr=00000200 state=1", imem_req, imem_addr, state); end
    step();
    n_checks++; if (valid !== 1'b1 || pc !== 32'h200) begin n_fail++; $display("FAIL ra_first: got valid=%b pc=%h want valid=1 pc=00000200", valid, pc); end
    step();
    n_checks++; if (valid !== 1'b1 || pc !== 32'h204) begin n_fail++; $display("FAIL ra_second: got valid=%b pc=%h want valid=1 pc=00000204", valid, pc); end
  endtask

  task automatic test_drop_overwrite();
    bit found;
    wait_cycles = 3;
    pcsrc = 1'b1; pctarget = 32'h300;
    step();
    n_checks++; if (state !== ST_DROP || valid !== 1'b0) begin n_fail++; $display("FAIL do_drop: got state=%0d valid=%b want state=2 valid=0", state, valid); end
    pctarget = 32'h400;
    step();
    pcsrc = 1'b0;
    n_checks++; if (state !== ST_DROP) begin n_fail++; $display("FAIL do_stay: got state=%0d want 2", state); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (valid === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found || pc !== 32'h400) begin n_fail++; $display("FAIL do_target: got found=%b pc=%h want pc=00000400", found, pc); end
  endtask

  task automatic test_reset_mid();
    wait_cycles = 0;
    step();
    step();
    // Reset together with a redirect and a pending ack: reset wins.
    rst = 1'b1; pcsrc = 1'b1; pctarget = 32'h500;
    step();
    pcsrc = 1'b0;
    n_checks++; if (valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_out: got valid=%b req=%b want valid=0 req=0", valid, imem_req); end
    n_checks++; if (state !== ST_IDLE || imem_addr !== 32'h0 || pc !== 32'h0) begin n_fail++; $display("FAIL rm_state: got state=%0d addr=%h pc=%h want state=0 addr=00000000 pc=00000000", state, imem_addr, pc); end
    rst = 1'b0;
    step();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_restart: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
    step();
    n_checks++; if (valid !== 1'b1 || pc !== 32'h0) begin n_fail++; $display("FAIL rm_first: got valid=%b pc=%h want valid=1 pc=00000000", valid, pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    w_rst = 1'b1;
    step();
    w_rst = 1'b0;
    step();
    n_checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_req: got req=%b addr=%h want req=1 addr=fffffff8", w_req, w_addr); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (w_valid !== 1'b1 || w_pc !== exp_pc[i] || w_instr !== (exp_pc[i] ^ K)) begin n_fail++; $display("FAIL wrap_pc[%0d]: got valid=%b pc=%h instr=%h want pc=%h instr=%h", i, w_valid, w_pc, w_instr, exp_pc[i], exp_pc[i] ^ K); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_drop_overwrite();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
